// File: rtl/spi_ram_arbiter.sv
// Shares one SPI RAM between the CPU and an auxiliary byte-access port.
// The CPU owns the bus unless an aux grant is in progress. The grant is raised only after the CPU bus has been idle for long enough.
module spi_ram_arbiter #(
  parameter int MIN_GAP    = 2,
  parameter int CPU_WINDOW = 4
) (
  input  logic        cpu_clk,
  input  logic        rstn,
  input  logic        cpu_spi_select_n,
  input  logic        cpu_spi_mosi,
  input  logic        cpu_spi_clk_en,
  output logic        cpu_spi_miso,
  output logic        cpu_hold,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [23:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic        aux_ack,
  output logic [7:0]  aux_rdata,
  output logic        aux_busy,
  output logic        spi_select_n,
  output logic        spi_mosi,
  output logic        spi_clk_en,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {IDLE, HOLD, SHIFT, DONE, COOLDOWN} state_t;

  localparam logic [3:0] GAP_LAST  = 4'(MIN_GAP - 1);
  localparam logic [3:0] COOL_LAST = 4'(CPU_WINDOW - 1);
  localparam logic [5:0] BIT_LAST  = 6'd39;

  state_t      state_q;
  logic [3:0]  gap_q;
  logic [3:0]  cool_q;
  logic [5:0]  bit_q;
  logic [39:0] shift_q;
  logic        we_q;
  logic        cpu_hold_q;
  logic        aux_ack_q;
  logic        aux_busy_q;
  logic [7:0]  aux_rdata_q;

  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      cool_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      we_q        <= 1'b0;
      cpu_hold_q  <= 1'b0;
      aux_ack_q   <= 1'b0;
      aux_busy_q  <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      aux_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aux_req) begin
            state_q    <= HOLD;
            cpu_hold_q <= 1'b1;
            gap_q      <= '0;
          end
        end
        HOLD: begin
          if (!aux_req) begin
            state_q    <= IDLE;
            cpu_hold_q <= 1'b0;
          end else if (!cpu_spi_select_n) begin
            gap_q <= '0;
          end else if (gap_q == GAP_LAST) begin
            state_q    <= SHIFT;
            aux_busy_q <= 1'b1;
            we_q       <= aux_we;
            bit_q      <= '0;
            shift_q    <= {(aux_we ? 8'h02 : 8'h03), aux_addr, (aux_we ? aux_wdata : 8'h00)};
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        SHIFT: begin
          // MISO enters at the bottom, so the last 8 bits sampled form the read byte.
          shift_q <= {shift_q[38:0], spi_miso};
          bit_q   <= bit_q + 6'd1;
          if (bit_q == BIT_LAST) begin
            state_q   <= DONE;
            aux_ack_q <= 1'b1;
            if (!we_q)
              aux_rdata_q <= {shift_q[6:0], spi_miso};
          end
        end
        DONE: begin
          state_q    <= COOLDOWN;
          cpu_hold_q <= 1'b0;
          aux_busy_q <= 1'b0;
          cool_q     <= '0;
        end
        COOLDOWN: begin
          // The last window cycle acts as IDLE, so a waiting requester re-holds the CPU after exactly CPU_WINDOW free cycles.
          if (cool_q == COOL_LAST) begin
            if (aux_req) begin
              state_q    <= HOLD;
              cpu_hold_q <= 1'b1;
              gap_q      <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cool_q <= cool_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    spi_select_n = cpu_spi_select_n;
    spi_mosi     = cpu_spi_mosi;
    spi_clk_en   = cpu_spi_clk_en;
    if (state_q == SHIFT) begin
      spi_select_n = 1'b0;
      spi_mosi     = shift_q[39];
      spi_clk_en   = 1'b1;
    end else if (state_q == DONE) begin
      spi_select_n = 1'b1;
      spi_mosi     = 1'b0;
      spi_clk_en   = 1'b0;
    end
  end

  assign cpu_spi_miso = spi_miso;
  assign cpu_hold     = cpu_hold_q;
  assign aux_ack      = aux_ack_q;
  assign aux_busy     = aux_busy_q;
  assign aux_rdata    = aux_rdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: it covers write, read, a busy CPU, fairness, mid-transfer reset and abort in HOLD.
module tb_spi_ram_arbiter;
  localparam int MIN_GAP    = 2;
  localparam int CPU_WINDOW = 4;

  logic        cpu_clk = 1'b0;
  logic        rstn;
  logic        cpu_spi_select_n, cpu_spi_mosi, cpu_spi_clk_en, cpu_spi_miso;
  logic        cpu_hold;
  logic        aux_req, aux_we, aux_ack, aux_busy;
  logic [23:0] aux_addr;
  logic [7:0]  aux_wdata, aux_rdata;
  logic        spi_select_n, spi_mosi, spi_clk_en, spi_miso;

  int          n_vec = 0;
  int          n_err = 0;
  int          n, viol, hold_low, busy_seen;
  logic [39:0] seen;

  spi_ram_arbiter #(.MIN_GAP(MIN_GAP), .CPU_WINDOW(CPU_WINDOW)) dut (
    .cpu_clk(cpu_clk), .rstn(rstn),
    .cpu_spi_select_n(cpu_spi_select_n), .cpu_spi_mosi(cpu_spi_mosi),
    .cpu_spi_clk_en(cpu_spi_clk_en), .cpu_spi_miso(cpu_spi_miso),
    .cpu_hold(cpu_hold), .aux_req(aux_req), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_ack(aux_ack),
    .aux_rdata(aux_rdata), .aux_busy(aux_busy),
    .spi_select_n(spi_select_n), .spi_mosi(spi_mosi),
    .spi_clk_en(spi_clk_en), .spi_miso(spi_miso)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #2;
  endtask

  task automatic wait_grant(input int max, output int cnt);
    cnt = 0;
    while (aux_busy !== 1'b1 && cnt < max) begin
      step();
      cnt++;
    end
  endtask

  // Entered in the first SHIFT cycle; leaves the bench in the DONE cycle.
  task automatic run_shift(input logic [7:0] miso_byte, input int poke_k,
                           output logic [39:0] got, output int bad);
    logic [7:0] mb;
    mb  = miso_byte;
    got = '0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      got = {got[38:0], spi_mosi};
      if (spi_select_n !== 1'b0 || spi_clk_en !== 1'b1 || aux_ack !== 1'b0 ||
          aux_busy !== 1'b1 || cpu_hold !== 1'b1)
        bad++;
      if (k >= 32) begin
        spi_miso = mb[7];
        mb = mb << 1;
      end else begin
        spi_miso = 1'b1;
      end
      if (k == poke_k) begin
        aux_req   = 1'b0;
        aux_we    = ~aux_we;
        aux_addr  = 24'hDEAD00;
        aux_wdata = 8'h5F;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cpu_spi_select_n = 1'b1; cpu_spi_mosi = 1'b0; cpu_spi_clk_en = 1'b0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0; spi_miso = 1'b0;
    repeat (3) step();

    check("rst_hold", cpu_hold, 0);
    check("rst_ack", aux_ack, 0);
    check("rst_busy", aux_busy, 0);
    check("rst_rdata", aux_rdata, 8'h00);
    cpu_spi_mosi = 1'b1; cpu_spi_clk_en = 1'b1; spi_miso = 1'b1;
    #1;
    check("rst_pt_sel", spi_select_n, 1);
    check("rst_pt_mosi", spi_mosi, 1);
    check("rst_pt_clken", spi_clk_en, 1);
    check("pt_miso", cpu_spi_miso, 1);
    rstn = 1'b1;
    step();

    // Write 0xA5 to 0x001234; aux inputs are scrambled mid-transfer.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 24'h001234; aux_wdata = 8'hA5;
    step();
    check("wr_hold_on", cpu_hold, 1);
    wait_grant(20, n);
    check("wr_grant_lat", n + 1, 1 + MIN_GAP);
    run_shift(8'hFF, 5, seen, viol);
    check("wr_mosi", seen, 40'h02001234A5);
    check("wr_shift_viol", viol, 0);
    check("wr_ack", aux_ack, 1);
    check("wr_done_sel", spi_select_n, 1);
    check("wr_done_clken", spi_clk_en, 0);
    check("wr_done_busy", aux_busy, 1);
    check("wr_rdata_kept", aux_rdata, 8'h00);
    step();
    check("wr_ack_pulse", aux_ack, 0);
    check("wr_cool_hold", cpu_hold, 0);
    check("wr_cool_busy", aux_busy, 0);
    cpu_spi_clk_en = 1'b0; cpu_spi_mosi = 1'b0;
    repeat (CPU_WINDOW + 2) step();

    // Read from 0x00FFFF, RAM returns 0x3C.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 24'h00FFFF;
    step();
    wait_grant(20, n);
    check("rd_grant_lat", n + 1, 1 + MIN_GAP);
    run_shift(8'h3C, -1, seen, viol);
    check("rd_mosi", seen, 40'h0300FFFF00);
    check("rd_shift_viol", viol, 0);
    check("rd_ack", aux_ack, 1);
    check("rd_rdata", aux_rdata, 8'h3C);
    aux_req = 1'b0;
    repeat (CPU_WINDOW + 2) step();
    check("rd_rdata_hold", aux_rdata, 8'h3C);

    // CPU mid-transaction for 20 cycles while aux waits.
    cpu_spi_select_n = 1'b0; cpu_spi_clk_en = 1'b1;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 24'hABCDEF;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      cpu_spi_mosi = c[0];
      #1;
      if (cpu_hold !== 1'b1 || aux_busy !== 1'b0 || spi_select_n !== 1'b0 ||
          spi_mosi !== cpu_spi_mosi || spi_clk_en !== 1'b1)
        viol++;
    end
    check("busy_pt_viol", viol, 0);
    cpu_spi_select_n = 1'b1; cpu_spi_clk_en = 1'b0;
    wait_grant(20, n);
    check("busy_grant_lat", n, MIN_GAP);
    run_shift(8'h5A, -1, seen, viol);
    check("busy_mosi", seen, 40'h03ABCDEF00);
    check("busy_shift_viol", viol, 0);
    check("busy_rdata", aux_rdata, 8'h5A);

    // aux_req stays high: CPU gets exactly CPU_WINDOW free cycles and uses them.
    hold_low = 0; busy_seen = 0; viol = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (cpu_hold === 1'b0) hold_low++;
      if (aux_busy === 1'b1) busy_seen++;
      cpu_spi_select_n = (c <= 6) ? 1'b0 : 1'b1;
      cpu_spi_mosi = c[1];
      #1;
      if (spi_select_n !== cpu_spi_select_n || spi_mosi !== cpu_spi_mosi) viol++;
    end
    check("fair_hold_low", hold_low, CPU_WINDOW);
    check("fair_no_busy", busy_seen, 0);
    check("fair_pt_viol", viol, 0);
    step();
    check("fair_grant", aux_busy, 1);
    run_shift(8'hC3, -1, seen, viol);
    check("fair_mosi", seen, 40'h03ABCDEF00);
    check("fair_shift_viol", viol, 0);
    check("fair_rdata", aux_rdata, 8'hC3);
    aux_req = 1'b0;
    repeat (CPU_WINDOW + 2) step();

    // Reset during SHIFT cycle 20.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 24'h000010; aux_wdata = 8'h81;
    step();
    wait_grant(20, n);
    repeat (19) step();
    check("mid_pre_sel", spi_select_n, 0);
    rstn = 1'b0; aux_req = 1'b0;
    step();
    check("mid_rst_sel", spi_select_n, 1);
    check("mid_rst_clken", spi_clk_en, 0);
    check("mid_rst_ack", aux_ack, 0);
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_busy", aux_busy, 0);
    rstn = 1'b1;
    viol = 0;
    repeat (45) begin
      step();
      if (aux_ack !== 1'b0 || aux_busy !== 1'b0 || cpu_hold !== 1'b0 || spi_select_n !== 1'b1) viol++;
    end
    check("mid_after_viol", viol, 0);

    // Abort in HOLD.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 24'h000001;
    step();
    check("abort_hold_on", cpu_hold, 1);
    aux_req = 1'b0;
    step();
    check("abort_hold_off", cpu_hold, 0);
    viol = 0;
    repeat (6) begin
      step();
      if (spi_select_n !== 1'b1 || spi_clk_en !== 1'b0 || aux_busy !== 1'b0 ||
          cpu_hold !== 1'b0 || aux_ack !== 1'b0)
        viol++;
    end
    check("abort_quiet_viol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
